// File: rtl/bp_me_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bp_me_pkg
// Brief    : Shared memory-engine types: arbiter FSM states, source-index width,
//            default processor configuration and the BedRock mem header struct.
// Revision : 1.0
// ============================================================================
package bp_me_pkg;

    typedef enum logic [0:0] {
        e_idle   = 1'b0,
        e_locked = 1'b1
    } bp_mem_arb_state_e;

    // Two requesters need a single-bit source index.
    localparam int c_src_width = 1;

    typedef enum logic [0:0] {
        e_bp_default_cfg = 1'b0
    } bp_params_e;

    localparam int c_paddr_width    = 40;
    localparam int c_did_width      = 3;
    localparam int c_lce_id_width   = 4;
    localparam int c_lce_assoc      = 8;
    localparam int c_uce_fill_width = 64;

    typedef struct packed {
        logic [c_did_width-1:0]          did;
        logic [c_lce_id_width-1:0]       lce_id;
        logic [$clog2(c_lce_assoc)-1:0]  way_id;
    } bp_bedrock_mem_payload_s;

    typedef struct packed {
        logic [3:0]                msg_type;
        logic [3:0]                subop;
        logic [c_paddr_width-1:0]  addr;
        logic [2:0]                size;
        bp_bedrock_mem_payload_s   payload;
    } bp_bedrock_mem_header_s;

    function automatic int bp_uce_fill_width(input bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return c_uce_fill_width;
            default:          return c_uce_fill_width;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/bsg_fifo_1r1w_small.sv
`default_nettype none
// ============================================================================
// Module   : bsg_fifo_1r1w_small
// Brief    : Small register FIFO, valid/ready on the write side, valid/yumi on
//            the read side. Fullness comes from registered occupancy only.
// Revision : 1.0
// ============================================================================
module bsg_fifo_1r1w_small #(
    parameter int WIDTH_P = 1,
    parameter int ELS_P   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_v,
    output logic               o_ready,
    input  logic [WIDTH_P-1:0] i_data,
    output logic               o_v,
    output logic [WIDTH_P-1:0] o_data,
    input  logic               i_yumi
);

    localparam int c_ptr_width = (ELS_P > 1) ? $clog2(ELS_P) : 1;
    localparam int c_cnt_width = $clog2(ELS_P + 1);

    logic [WIDTH_P-1:0]     r_mem [ELS_P];
    logic [c_ptr_width-1:0] r_wptr;
    logic [c_ptr_width-1:0] r_rptr;
    logic [c_cnt_width-1:0] r_count;
    logic                   w_push;
    logic                   w_pop;

    function automatic logic [c_ptr_width-1:0] f_next(input logic [c_ptr_width-1:0] p);
        return (p == c_ptr_width'(ELS_P - 1)) ? '0 : p + c_ptr_width'(1);
    endfunction

    assign o_ready = (r_count != c_cnt_width'(ELS_P));
    assign o_v     = (r_count != '0);
    assign o_data  = r_mem[r_rptr];
    assign w_push  = i_v & o_ready;
    assign w_pop   = i_yumi & o_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= f_next(r_wptr);
            if (w_pop)  r_rptr <= f_next(r_rptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_width'(1);
                2'b01:   r_count <= r_count - c_cnt_width'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/bp_mem_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bp_mem_stream_arbiter
// Brief    : Merges the I$ (0) and D$ (1) UCE mem streams onto one port, keeping
//            multi-beat commands atomic and steering in-order responses back.
// Options  : BP_MEM_ARB_ROUND_ROBIN_EN - round-robin instead of fixed D$ priority
// Revision : 1.0
// ============================================================================
module bp_mem_stream_arbiter
    import bp_me_pkg::*;
#(
    parameter bp_params_e BP_PARAMS_P   = e_bp_default_cfg,
    parameter int         OUTSTANDING_P = 4,
    localparam int c_hdr_width  = $bits(bp_bedrock_mem_header_s),
    localparam int c_fill_width = bp_uce_fill_width(BP_PARAMS_P)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,

    input  logic [1:0][c_hdr_width-1:0]  mem_cmd_header_i,
    input  logic [1:0][c_fill_width-1:0] mem_cmd_data_i,
    input  logic [1:0]                   mem_cmd_v_i,
    input  logic [1:0]                   mem_cmd_last_i,
    output logic [1:0]                   mem_cmd_ready_and_o,

    output logic [c_hdr_width-1:0]       mem_cmd_header_o,
    output logic [c_fill_width-1:0]      mem_cmd_data_o,
    output logic                         mem_cmd_v_o,
    output logic                         mem_cmd_last_o,
    input  logic                         mem_cmd_ready_and_i,

    input  logic [c_hdr_width-1:0]       mem_resp_header_i,
    input  logic [c_fill_width-1:0]      mem_resp_data_i,
    input  logic                         mem_resp_v_i,
    input  logic                         mem_resp_last_i,
    output logic                         mem_resp_ready_and_o,

    output logic [1:0][c_hdr_width-1:0]  mem_resp_header_o,
    output logic [1:0][c_fill_width-1:0] mem_resp_data_o,
    output logic [1:0]                   mem_resp_v_o,
    output logic [1:0]                   mem_resp_last_o,
    input  logic [1:0]                   mem_resp_ready_and_i
);

    bp_mem_arb_state_e      r_state;
    bp_mem_arb_state_e      w_state_next;
    logic [c_src_width-1:0] r_grant;
    logic [c_src_width-1:0] w_grant_next;
    logic [c_src_width-1:0] w_pick;
    logic [c_src_width-1:0] w_sel;
    logic [c_src_width-1:0] w_fifo_head;
    logic                   w_fifo_ready;
    logic                   w_fifo_v;
    logic                   w_fwd_en;
    logic                   w_sel_v;
    logic                   w_sel_last;
    logic                   w_cmd_hs;
    logic                   w_push;
    logic                   w_pop;

`ifdef BP_MEM_ARB_ROUND_ROBIN_EN
    logic [c_src_width-1:0] r_rr_ptr;

    // The pointer only breaks ties; a lone requester always wins.
    assign w_pick = (&mem_cmd_v_i) ? r_rr_ptr : mem_cmd_v_i[1];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rr_ptr <= '0;
        end else if (w_cmd_hs && w_sel_last) begin
            r_rr_ptr <= ~w_sel;
        end
    end
`else
    assign w_pick = mem_cmd_v_i[1];
`endif

    // A locked message was already counted in the FIFO, so fullness only gates new starts.
    assign w_sel      = (r_state == e_locked) ? r_grant : w_pick;
    assign w_fwd_en   = (r_state == e_locked) | w_fifo_ready;
    assign w_sel_v    = mem_cmd_v_i[w_sel];
    assign w_sel_last = mem_cmd_last_i[w_sel];

    assign mem_cmd_v_o      = ~reset_i & w_fwd_en & w_sel_v;
    assign mem_cmd_last_o   = w_sel_last;
    assign mem_cmd_header_o = mem_cmd_header_i[w_sel];
    assign mem_cmd_data_o   = mem_cmd_data_i[w_sel];
    assign w_cmd_hs         = mem_cmd_v_o & mem_cmd_ready_and_i;

    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_push       = 1'b0;
        case (r_state)
            e_idle: begin
                w_push = w_cmd_hs;
                if (w_cmd_hs && !w_sel_last) begin
                    w_state_next = e_locked;
                    w_grant_next = w_sel;
                end
            end
            e_locked: begin
                if (w_cmd_hs && w_sel_last) w_state_next = e_idle;
            end
            default: w_state_next = e_idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= e_idle;
            r_grant <= '0;
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
        end
    end

    bsg_fifo_1r1w_small #(
        .WIDTH_P (c_src_width),
        .ELS_P   (OUTSTANDING_P)
    ) u_src_fifo (
        .clk     (clk_i),
        .rst     (reset_i),
        .i_v     (w_push),
        .o_ready (w_fifo_ready),
        .i_data  (w_sel),
        .o_v     (w_fifo_v),
        .o_data  (w_fifo_head),
        .i_yumi  (w_pop)
    );

    assign mem_resp_ready_and_o = ~reset_i & w_fifo_v & mem_resp_ready_and_i[w_fifo_head];
    assign w_pop                = mem_resp_v_i & mem_resp_ready_and_o & mem_resp_last_i;
    assign mem_resp_header_o    = {2{mem_resp_header_i}};
    assign mem_resp_data_o      = {2{mem_resp_data_i}};

    always_comb begin
        mem_cmd_ready_and_o                = '0;
        mem_cmd_ready_and_o[w_sel]         = ~reset_i & w_fwd_en & mem_cmd_ready_and_i;
        mem_resp_v_o                       = '0;
        mem_resp_last_o                    = '0;
        mem_resp_v_o[w_fifo_head]          = ~reset_i & w_fifo_v & mem_resp_v_i;
        mem_resp_last_o[w_fifo_head]       = ~reset_i & w_fifo_v & mem_resp_last_i;
    end

    // A response with nothing outstanding cannot be routed anywhere.
    a_resp_has_owner: assert property (@(posedge clk_i) disable iff (reset_i)
        mem_resp_v_i |-> w_fifo_v);

endmodule
`default_nettype wire

// File: tb/tb_bp_mem_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_mem_stream_arbiter
// Brief    : Directed and randomized bench with a message-level reference model.
// Revision : 1.0
// ============================================================================
module tb_bp_mem_stream_arbiter;
    import bp_me_pkg::*;

    localparam int c_hw  = $bits(bp_bedrock_mem_header_s);
    localparam int c_fw  = bp_uce_fill_width(e_bp_default_cfg);
    localparam int c_out = 4;

    logic                  clk = 1'b0;
    logic                  reset_i;
    logic [1:0][c_hw-1:0]  cmd_hdr;
    logic [1:0][c_fw-1:0]  cmd_data;
    logic [1:0]            cmd_v, cmd_last, cmd_rdy_o;
    logic [c_hw-1:0]       cmd_hdr_o;
    logic [c_fw-1:0]       cmd_data_o;
    logic                  cmd_v_o, cmd_last_o, down_rdy;
    logic [c_hw-1:0]       resp_hdr_i;
    logic [c_fw-1:0]       resp_data_i;
    logic                  resp_v_i, resp_last_i, resp_rdy_o;
    logic [1:0][c_hw-1:0]  resp_hdr_o;
    logic [1:0][c_fw-1:0]  resp_data_o;
    logic [1:0]            resp_v_o, resp_last_o, resp_rdy_i;

    int total = 0;
    int bad   = 0;

    bp_mem_stream_arbiter #(
        .BP_PARAMS_P   (e_bp_default_cfg),
        .OUTSTANDING_P (c_out)
    ) dut (
        .clk_i                (clk),
        .reset_i              (reset_i),
        .mem_cmd_header_i     (cmd_hdr),
        .mem_cmd_data_i       (cmd_data),
        .mem_cmd_v_i          (cmd_v),
        .mem_cmd_last_i       (cmd_last),
        .mem_cmd_ready_and_o  (cmd_rdy_o),
        .mem_cmd_header_o     (cmd_hdr_o),
        .mem_cmd_data_o       (cmd_data_o),
        .mem_cmd_v_o          (cmd_v_o),
        .mem_cmd_last_o       (cmd_last_o),
        .mem_cmd_ready_and_i  (down_rdy),
        .mem_resp_header_i    (resp_hdr_i),
        .mem_resp_data_i      (resp_data_i),
        .mem_resp_v_i         (resp_v_i),
        .mem_resp_last_i      (resp_last_i),
        .mem_resp_ready_and_o (resp_rdy_o),
        .mem_resp_header_o    (resp_hdr_o),
        .mem_resp_data_o      (resp_data_o),
        .mem_resp_v_o         (resp_v_o),
        .mem_resp_last_o      (resp_last_o),
        .mem_resp_ready_and_i (resp_rdy_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: message-level view of the port ----------------
    int   q_src[$];
    int   m_owner = -1;
    int   m_pref  = 0;
    int   m_sel, m_head;
    bit   m_en, m_qv;
    logic m_exp_cv;

    always @(negedge clk) begin
        if (reset_i) begin
            check("rst_cmd_v", 128'(cmd_v_o), 128'(0));
            check("rst_cmd_rdy", 128'(cmd_rdy_o), 128'(0));
            check("rst_resp_v", 128'(resp_v_o), 128'(0));
            check("rst_resp_rdy", 128'(resp_rdy_o), 128'(0));
            q_src.delete();
            m_owner = -1;
            m_pref  = 0;
        end else begin
            if (m_owner >= 0) begin
                m_en  = 1'b1;
                m_sel = m_owner;
            end else begin
                m_en = (q_src.size() < c_out);
`ifdef BP_MEM_ARB_ROUND_ROBIN_EN
                m_sel = (cmd_v == 2'b11) ? m_pref : (cmd_v[1] ? 1 : 0);
`else
                m_sel = cmd_v[1] ? 1 : 0;
`endif
            end
            m_exp_cv = m_en && cmd_v[m_sel];
            check("cmd_v", 128'(cmd_v_o), 128'(m_exp_cv));
            check("cmd_rdy_other", 128'(cmd_rdy_o[1-m_sel]), 128'(0));
            if (cmd_v[m_sel]) check("cmd_rdy_sel", 128'(cmd_rdy_o[m_sel]), 128'(m_en && down_rdy));
            if (m_exp_cv) begin
                check("cmd_hdr", 128'(cmd_hdr_o), 128'(cmd_hdr[m_sel]));
                check("cmd_data", 128'(cmd_data_o), 128'(cmd_data[m_sel]));
                check("cmd_last", 128'(cmd_last_o), 128'(cmd_last[m_sel]));
            end

            m_qv   = (q_src.size() > 0);
            m_head = m_qv ? q_src[0] : 0;
            check("resp_v", 128'(resp_v_o), m_qv && resp_v_i ? 128'(1 << m_head) : 128'(0));
            check("resp_rdy", 128'(resp_rdy_o), 128'(m_qv && resp_rdy_i[m_head]));
            if (resp_v_i) begin
                check("resp_last", 128'(resp_last_o[m_head]), 128'(resp_last_i));
                check("resp_hdr", 128'(resp_hdr_o[m_head]), 128'(resp_hdr_i));
                check("resp_data", 128'(resp_data_o[1-m_head]), 128'(resp_data_i));
            end

            if (m_qv && resp_v_i && resp_rdy_i[m_head] && resp_last_i) void'(q_src.pop_front());
            if (m_exp_cv && down_rdy) begin
                if (m_owner < 0) begin
                    q_src.push_back(m_sel);
                    if (!cmd_last[m_sel]) m_owner = m_sel;
                end else if (cmd_last[m_sel]) begin
                    m_owner = -1;
                end
                if (cmd_last[m_sel]) m_pref = 1 - m_sel;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    int         ract[2], rbeat[2], rlen[2];
    int         rs_act, rs_beat, rs_len, pending, in_msg;
    logic [1:0] hs_cmd;
    logic       hs_out, out_last_s, hs_resp;
    logic [1:0] arb_exp[4];

    initial begin
        reset_i = 1'b1; cmd_v = 2'b11; cmd_last = 2'b11; down_rdy = 1'b1;
        cmd_hdr = '0; cmd_data = '0; resp_hdr_i = '0; resp_data_i = '0;
        resp_v_i = 1'b0; resp_last_i = 1'b0; resp_rdy_i = 2'b11;
        repeat (3) step();
        settle();
        check("lit_reset_cmd_v", 128'(cmd_v_o), 128'(0));

        // single-beat I$ read and its one-beat response
        step(); reset_i = 1'b0; cmd_v = 2'b01; cmd_last = 2'b01;
        cmd_hdr[0] = c_hw'(rnd128()); cmd_data[0] = c_fw'(rnd128());
        settle();
        check("lit_t1_cmd_v", 128'(cmd_v_o), 128'(1));
        check("lit_t1_rdy", 128'(cmd_rdy_o), 128'(2'b01));
        step(); cmd_v = 2'b00; resp_v_i = 1'b1; resp_last_i = 1'b1;
        settle();
        check("lit_t1_resp_v", 128'(resp_v_o), 128'(2'b01));
        check("lit_t1_resp_rdy", 128'(resp_rdy_o), 128'(1));
        step(); resp_v_i = 1'b0;
        settle();
        check("lit_t1_empty", 128'(resp_rdy_o), 128'(0));

        // D$ 4-beat write, I$ arrives on beat 2 and waits for the D$ last beat
        for (int b = 0; b < 4; b++) begin
            step();
            cmd_v = (b == 0) ? 2'b10 : 2'b11;
            cmd_last = {b == 3, 1'b1};
            cmd_hdr[1] = c_hw'(rnd128()); cmd_data[1] = c_fw'(rnd128());
            settle();
            check("lit_t2_dlocked", 128'(cmd_rdy_o), 128'(2'b10));
        end
        step(); cmd_v = 2'b01;
        settle();
        check("lit_t2_i_next", 128'(cmd_rdy_o), 128'(2'b01));
        // responses return D$ then I$; D$ response-ready held low 3 cycles
        step(); cmd_v = 2'b00; resp_v_i = 1'b1; resp_last_i = 1'b1; resp_rdy_i = 2'b01;
        for (int c = 0; c < 3; c++) begin
            settle();
            check("lit_t5_stall_rdy", 128'(resp_rdy_o), 128'(0));
            check("lit_t5_stall_v", 128'(resp_v_o), 128'(2'b10));
            step();
        end
        resp_rdy_i = 2'b11;
        settle();
        check("lit_t5_d_go", 128'(resp_rdy_o), 128'(1));
        step();
        settle();
        check("lit_t5_i_route", 128'(resp_v_o), 128'(2'b01));
        step(); resp_v_i = 1'b0;

        // outstanding limit: 4 commands in flight hold off the 5th
        cmd_v = 2'b01; cmd_last = 2'b11;
        for (int c = 0; c < 4; c++) begin
            settle();
            check("lit_t3_issue", 128'(cmd_v_o), 128'(1));
            step();
        end
        settle();
        check("lit_t3_full_v", 128'(cmd_v_o), 128'(0));
        check("lit_t3_full_rdy", 128'(cmd_rdy_o), 128'(0));
        step(); resp_v_i = 1'b1;
        settle();
        check("lit_t3_no_rescue", 128'(cmd_v_o), 128'(0));
        step(); resp_v_i = 1'b0;
        settle();
        check("lit_t3_fifth", 128'(cmd_rdy_o), 128'(2'b01));
        step(); cmd_v = 2'b00; resp_v_i = 1'b1;
        repeat (4) step();
        resp_v_i = 1'b0;

        // reset in the middle of a D$ multi-beat command
        cmd_v = 2'b10; cmd_last = 2'b00;
        step(); step();
        reset_i = 1'b1;
        settle();
        check("lit_t6_cmd_v", 128'(cmd_v_o), 128'(0));
        check("lit_t6_resp_rdy", 128'(resp_rdy_o), 128'(0));

        // both requesters valid every cycle right after reset
`ifdef BP_MEM_ARB_ROUND_ROBIN_EN
        arb_exp[0] = 2'b01; arb_exp[1] = 2'b10; arb_exp[2] = 2'b01; arb_exp[3] = 2'b10;
`else
        arb_exp[0] = 2'b10; arb_exp[1] = 2'b10; arb_exp[2] = 2'b10; arb_exp[3] = 2'b10;
`endif
        step(); reset_i = 1'b0; cmd_v = 2'b11; cmd_last = 2'b11;
        settle();
        check("lit_t6_fifo_empty", 128'(resp_rdy_o), 128'(0));
        for (int c = 0; c < 4; c++) begin
            if (c > 0) begin step(); settle(); end
            check("lit_t4_grant", 128'(cmd_rdy_o), 128'(arb_exp[c]));
        end
        step(); cmd_v = 2'b00; resp_v_i = 1'b1; resp_last_i = 1'b1;
        repeat (4) step();
        resp_v_i = 1'b0;

        // randomized traffic; the model checks every cycle
        ract = '{0, 0}; rbeat = '{0, 0}; rlen = '{1, 1};
        rs_act = 0; rs_beat = 0; rs_len = 1; pending = 0; in_msg = 0;
        hs_cmd = 2'b00; hs_out = 1'b0; out_last_s = 1'b0; hs_resp = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int r = 0; r < 2; r++) begin
                if (hs_cmd[r]) begin
                    if (cmd_last[r]) ract[r] = 0;
                    else begin rbeat[r]++; cmd_data[r] = c_fw'(rnd128()); end
                end
                if (ract[r] == 0 && $urandom_range(2) == 0) begin
                    ract[r] = 1; rbeat[r] = 0; rlen[r] = $urandom_range(4, 1);
                    cmd_hdr[r] = c_hw'(rnd128()); cmd_data[r] = c_fw'(rnd128());
                end
                cmd_v[r]    = (ract[r] != 0);
                cmd_last[r] = (ract[r] != 0) && (rbeat[r] == rlen[r] - 1);
            end
            if (hs_out) begin
                if (in_msg == 0) pending++;
                in_msg = out_last_s ? 0 : 1;
            end
            if (hs_resp) begin
                if (resp_last_i) begin pending--; rs_act = 0; end
                else begin rs_beat++; resp_data_i = c_fw'(rnd128()); end
            end
            if (rs_act == 0 && pending > 0 && $urandom_range(1) == 0) begin
                rs_act = 1; rs_beat = 0; rs_len = $urandom_range(2, 1);
                resp_hdr_i = c_hw'(rnd128()); resp_data_i = c_fw'(rnd128());
            end
            resp_v_i    = (rs_act != 0);
            resp_last_i = (rs_act != 0) && (rs_beat == rs_len - 1);
            down_rdy    = ($urandom_range(3) != 0);
            resp_rdy_i  = {$urandom_range(3) != 0, $urandom_range(3) != 0};
            settle();
            hs_cmd     = cmd_v & cmd_rdy_o;
            hs_out     = cmd_v_o & down_rdy;
            out_last_s = cmd_last_o;
            hs_resp    = resp_v_i & resp_rdy_o;
            step();
        end

        cmd_v = 2'b00; resp_v_i = 1'b0;
        repeat (2) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
